// File: rtl/uart_cmd_scheduler.sv
// Arbitrates drive commands, e-stop, telemetry queries and periodic refresh
// into single UART frames, with a done timeout, retry and inter-frame gap.
module uart_cmd_scheduler #(
  parameter int unsigned REFRESH_CYCLES = 25_000_000,
  parameter int unsigned TIMEOUT_CYCLES = 5_000_000,
  parameter int unsigned GAP_CYCLES     = 434
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  input  logic [2:0]  cmd_code,
  input  logic        estop,
  input  logic        query_req,
  input  logic        tx_done,
  output logic        frame_start,
  output logic [2:0]  frame_sel,
  output logic        busy,
  output logic [2:0]  cur_cmd,
  output logic [15:0] frame_count,
  output logic        err_timeout
);

  // state     | meaning
  // IDLE      | no frame in flight; arbitrate pending requests
  // ISSUE     | one-cycle frame_start pulse, winning flag clears
  // WAIT_DONE | frame in flight, waiting for tx_done or timeout
  // GAP       | mandatory idle time between frames
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, GAP} state_t;
  typedef enum logic [1:0] {W_ESTOP, W_CMD, W_QUERY, W_REF} win_t;

  localparam logic [2:0]  SEL_STOP     = 3'd0;
  localparam logic [2:0]  SEL_QUERY    = 3'd5;
  localparam logic [31:0] REF_LOAD     = 32'(REFRESH_CYCLES - 1);
  localparam logic [31:0] TIMEOUT_LOAD = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0] GAP_LOAD     = 32'(GAP_CYCLES - 1);

  state_t      state, state_nxt;
  win_t        win, win_nxt;
  logic [2:0]  sel_nxt;
  logic [31:0] timer, ref_timer;
  logic [2:0]  pend_cmd;
  logic        pend_cmd_f, pend_estop, pend_q, pend_ref, estop_d;
  logic [2:0]  eff_cmd;
  logic        estop_rise, cmd_take, issue, done, tmo;

  assign eff_cmd    = pend_cmd_f ? pend_cmd : cur_cmd;
  assign estop_rise = estop & ~estop_d;
  assign cmd_take   = cmd_valid & ~estop & (cmd_code <= 3'd4) & (cmd_code != eff_cmd);
  assign issue      = (state == ISSUE);
  assign done       = (state == WAIT_DONE) & tx_done;
  assign tmo        = (state == WAIT_DONE) & ~tx_done & (timer == 32'd0);

  always_comb begin
    state_nxt   = state;
    win_nxt     = win;
    sel_nxt     = frame_sel;
    frame_start = 1'b0;
    busy        = 1'b0;
    case (state)
      IDLE: begin
        if (pend_estop) begin
          sel_nxt = SEL_STOP;  win_nxt = W_ESTOP; state_nxt = ISSUE;
        end else if (pend_cmd_f) begin
          sel_nxt = pend_cmd;  win_nxt = W_CMD;   state_nxt = ISSUE;
        end else if (pend_q) begin
          sel_nxt = SEL_QUERY; win_nxt = W_QUERY; state_nxt = ISSUE;
        end else if (pend_ref) begin
          sel_nxt = cur_cmd;   win_nxt = W_REF;   state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        frame_start = 1'b1;
        busy        = 1'b1;
        state_nxt   = WAIT_DONE;
      end
      WAIT_DONE: begin
        busy = 1'b1;
        if (tx_done || timer == 32'd0) state_nxt = GAP;
      end
      GAP: if (timer == 32'd0) state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      win       <= W_ESTOP;
      frame_sel <= SEL_STOP;
    end else begin
      state     <= state_nxt;
      win       <= win_nxt;
      frame_sel <= sel_nxt;
    end
  end

  // One down-counter serves both the done timeout and the gap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) timer <= 32'd0;
    else begin
      case (state)
        ISSUE:     timer <= TIMEOUT_LOAD;
        WAIT_DONE: timer <= (tx_done || timer == 32'd0) ? GAP_LOAD : timer - 32'd1;
        GAP:       if (timer != 32'd0) timer <= timer - 32'd1;
        default:   timer <= timer;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estop_d     <= 1'b0;
      pend_cmd    <= 3'd0;
      pend_cmd_f  <= 1'b0;
      pend_estop  <= 1'b0;
      pend_q      <= 1'b0;
      pend_ref    <= 1'b0;
      cur_cmd     <= 3'd0;
      frame_count <= 16'd0;
      err_timeout <= 1'b0;
      ref_timer   <= REF_LOAD;
    end else begin
      estop_d <= estop;
      if (issue) begin
        case (win)
          W_ESTOP: begin
            pend_estop <= 1'b0;
            if (pend_cmd == SEL_STOP) pend_cmd_f <= 1'b0;
          end
          W_CMD:   pend_cmd_f <= 1'b0;
          W_QUERY: pend_q     <= 1'b0;
          W_REF:   pend_ref   <= 1'b0;
        endcase
        if (frame_sel != SEL_QUERY) cur_cmd <= frame_sel;
      end
      // Aborted frame: re-arm its flag unless a newer command superseded it.
      if (tmo) begin
        err_timeout <= 1'b1;
        case (win)
          W_ESTOP: pend_estop <= 1'b1;
          W_CMD: if (!pend_cmd_f) begin
            pend_cmd   <= frame_sel;
            pend_cmd_f <= 1'b1;
          end
          W_QUERY: pend_q   <= 1'b1;
          W_REF:   pend_ref <= 1'b1;
        endcase
      end
      if (done) frame_count <= frame_count + 16'd1;
      if (issue) ref_timer <= REF_LOAD;
      else if (state == IDLE) begin
        if (ref_timer == 32'd0) pend_ref <= 1'b1;
        else ref_timer <= ref_timer - 32'd1;
      end
      // New requests come last so they survive a same-cycle clear.
      if (query_req) pend_q <= 1'b1;
      if (cmd_take) begin
        pend_cmd   <= cmd_code;
        pend_cmd_f <= 1'b1;
      end
      if (estop_rise) begin
        pend_cmd   <= SEL_STOP;
        pend_cmd_f <= 1'b1;
        pend_estop <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_scheduler.sv
// Directed bench for uart_cmd_scheduler: table of command strobes plus
// hand-written sequences for gap, merge, estop, query, timeout, refresh, reset.
module tb_uart_cmd_scheduler;

  logic        clk, rst, cmd_valid, estop, query_req, tx_done;
  logic [2:0]  cmd_code;
  logic        frame_start, busy, err_timeout;
  logic [2:0]  frame_sel, cur_cmd;
  logic [15:0] frame_count;

  int n_vec, n_miss, exp_count, exp_cur;

  typedef struct {
    logic [2:0] code;
    bit         exp_frame;
    logic [2:0] exp_sel;
  } vec_t;
  vec_t tbl[9];

  uart_cmd_scheduler #(
    .REFRESH_CYCLES(100), .TIMEOUT_CYCLES(50), .GAP_CYCLES(4)
  ) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_code(cmd_code),
    .estop(estop), .query_req(query_req), .tx_done(tx_done),
    .frame_start(frame_start), .frame_sel(frame_sel), .busy(busy),
    .cur_cmd(cur_cmd), .frame_count(frame_count), .err_timeout(err_timeout)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(string name, int act, int exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic send_cmd(logic [2:0] c);
    cmd_valid = 1; cmd_code = c;
    step();
    cmd_valid = 0;
  endtask

  task automatic wait_start(int max, string name);
    int seen = 0;
    for (int i = 0; i < max && seen == 0; i++) begin
      if (frame_start) seen = 1;
      else step();
    end
    check(name, seen, 1);
  endtask

  task automatic no_start(int n, string name);
    int seen = 0;
    repeat (n) begin
      step();
      if (frame_start) seen++;
    end
    check(name, seen, 0);
  endtask

  // Called in the ISSUE cycle: completes the frame after dly cycles and drains the gap.
  task automatic finish_frame(int dly, string name);
    repeat (dly) step();
    tx_done = 1;
    step();
    tx_done = 0;
    exp_count++;
    check({name, " count"}, frame_count, exp_count);
    check({name, " busy"}, busy, 0);
    repeat (4) step();
  endtask

  initial begin
    n_vec = 0; n_miss = 0; exp_count = 0; exp_cur = 0;
    rst = 1; cmd_valid = 0; cmd_code = 0; estop = 0; query_req = 0; tx_done = 0;

    tbl[0] = '{3'd1, 1'b1, 3'd1};
    tbl[1] = '{3'd1, 1'b0, 3'd0};
    tbl[2] = '{3'd6, 1'b0, 3'd0};
    tbl[3] = '{3'd2, 1'b1, 3'd2};
    tbl[4] = '{3'd7, 1'b0, 3'd0};
    tbl[5] = '{3'd0, 1'b1, 3'd0};
    tbl[6] = '{3'd4, 1'b1, 3'd4};
    tbl[7] = '{3'd4, 1'b0, 3'd0};
    tbl[8] = '{3'd5, 1'b0, 3'd0};

    repeat (3) step();
    check("rst frame_start", frame_start, 0);
    check("rst frame_sel", frame_sel, 0);
    check("rst busy", busy, 0);
    check("rst cur_cmd", cur_cmd, 0);
    check("rst frame_count", frame_count, 0);
    check("rst err_timeout", err_timeout, 0);
    rst = 0;
    repeat (2) step();

    for (int i = 0; i < 9; i++) begin
      send_cmd(tbl[i].code);
      step();
      check($sformatf("vec%0d frame_start", i), frame_start, int'(tbl[i].exp_frame));
      if (tbl[i].exp_frame) begin
        check($sformatf("vec%0d frame_sel", i), frame_sel, tbl[i].exp_sel);
        check($sformatf("vec%0d busy", i), busy, 1);
        finish_frame(5, $sformatf("vec%0d", i));
        exp_cur = tbl[i].exp_sel;
      end else begin
        no_start(3, $sformatf("vec%0d no frame", i));
      end
      check($sformatf("vec%0d cur_cmd", i), cur_cmd, exp_cur);
    end

    // basic frame, then a command arriving in the gap starts exactly after 4 gap cycles
    send_cmd(1);
    step();
    check("basic frame_start", frame_start, 1);
    check("basic frame_sel", frame_sel, 1);
    repeat (20) step();
    check("basic busy wait", busy, 1);
    tx_done = 1;
    step();
    tx_done = 0;
    exp_count++;
    check("basic count", frame_count, exp_count);
    check("basic busy gap", busy, 0);
    cmd_valid = 1; cmd_code = 2;
    step();
    cmd_valid = 0;
    repeat (3) step();
    check("gap no early start", frame_start, 0);
    step();
    check("gap start after idle", frame_start, 1);
    check("gap frame_sel", frame_sel, 2);
    finish_frame(3, "gap");

    // two commands while busy: only the latest is sent
    send_cmd(1);
    step();
    check("merge first sel", frame_sel, 1);
    step();
    send_cmd(3);
    send_cmd(4);
    repeat (3) step();
    tx_done = 1;
    step();
    tx_done = 0;
    exp_count++;
    check("merge count", frame_count, exp_count);
    wait_start(10, "merge start");
    check("merge sel", frame_sel, 4);
    finish_frame(3, "merge");
    no_start(10, "merge one extra");

    // estop during a frame: frame completes, STOP follows, commands ignored
    send_cmd(2);
    step();
    check("estop first sel", frame_sel, 2);
    step();
    estop = 1;
    step();
    cmd_valid = 1; cmd_code = 1;
    step();
    cmd_valid = 0;
    check("estop no abort busy", busy, 1);
    repeat (3) step();
    tx_done = 1;
    step();
    tx_done = 0;
    exp_count++;
    check("estop count", frame_count, exp_count);
    wait_start(10, "estop start");
    check("estop sel", frame_sel, 0);
    finish_frame(3, "estop");
    check("estop cur_cmd", cur_cmd, 0);
    no_start(10, "estop cmd ignored");
    estop = 0;
    step();

    // query and command together: command first, then query
    query_req = 1; cmd_valid = 1; cmd_code = 1;
    step();
    query_req = 0; cmd_valid = 0;
    step();
    check("qc first start", frame_start, 1);
    check("qc first sel", frame_sel, 1);
    finish_frame(2, "qc first");
    wait_start(10, "qc query start");
    check("qc query sel", frame_sel, 5);
    finish_frame(2, "qc query");
    check("qc cur_cmd", cur_cmd, 1);
    tx_done = 1;
    step();
    tx_done = 0;
    step();
    check("stray tx_done count", frame_count, exp_count);

    // timeout and retry
    send_cmd(2);
    step();
    check("tmo sel", frame_sel, 2);
    repeat (40) step();
    check("tmo not yet", err_timeout, 0);
    begin
      int seen = 0;
      for (int i = 0; i < 20 && seen == 0; i++) begin
        step();
        if (err_timeout) seen = 1;
      end
      check("tmo flag", seen, 1);
    end
    check("tmo busy", busy, 0);
    check("tmo count unchanged", frame_count, exp_count);
    wait_start(10, "tmo retry start");
    check("tmo retry sel", frame_sel, 2);
    finish_frame(2, "tmo retry");
    check("tmo sticky", err_timeout, 1);

    // refresh after 100 idle cycles; invalid and repeated codes send nothing
    send_cmd(3);
    step();
    check("ref cmd sel", frame_sel, 3);
    finish_frame(2, "ref cmd");
    send_cmd(6);
    send_cmd(3);
    no_start(90, "ref quiet");
    wait_start(20, "ref start");
    check("ref sel", frame_sel, 3);
    finish_frame(2, "ref");
    check("ref cur_cmd", cur_cmd, 3);

    // reset mid-frame, estop held through reset release gives one STOP
    send_cmd(1);
    repeat (3) step();
    rst = 1; estop = 1;
    #1;
    exp_count = 0;
    check("midrst busy", busy, 0);
    check("midrst count", frame_count, 0);
    check("midrst cur_cmd", cur_cmd, 0);
    check("midrst err", err_timeout, 0);
    step();
    rst = 0;
    wait_start(5, "rst estop start");
    check("rst estop sel", frame_sel, 0);
    finish_frame(2, "rst estop");
    no_start(10, "rst estop single");
    estop = 0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
